phase_accum_encoder: RTL and testbench
======================================

# phase_accum_encoder

Phase accumulator that produces the 4-bit phase code `x_s1[3:0]` consumed by the multiphase clock-select decoder. Each clock it adds a programmable step word to a fixed-point phase register and presents the integer phase bits. Those bits select one of 16 phase positions, which the decoder maps to even/odd clock-mux selects.
- Step changes arrive through a valid/ready handshake and are applied only at a phase wrap, so the selected clock never glitches.
- Start/stop is controlled by a run/stop state machine.

## Interface
- `FRAC_W`, default 8: fractional bits of the accumulator; total width `AW = 4 + FRAC_W`.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `run` in, 1: level; 1 = accumulate, 0 = stop at the next wrap.
- `step_in` in, AW: new step word (4 integer . FRAC_W fraction).
- `step_valid` in, 1: `step_in` offered.
- `step_ready` out, 1: pending slot empty; transfer occurs when `step_valid & step_ready`.
- `x_s1` out, 4: `acc[AW-1:AW-4]`, integer phase code to the decoder.
- `phase_frac` out, FRAC_W: `acc[FRAC_W-1:0]`.
- `wrap` out, 1: one-cycle pulse, asserted when `acc` holds a value produced by a carry out of bit AW-1.
- `busy` out, 1: state ≠ IDLE.

## Operation
- Registers:
  - `acc[AW-1:0]`
  - `step[AW-1:0]`, the active step
  - `pend[AW-1:0]` with `pend_full`
  - state: IDLE / RUN / STOP
- Sum is `{carry, sum} = acc + step`, (AW+1)-bit. Arithmetic is unsigned modulo 2^AW; the carry is `wrap`.
- Handshake:
  - `step_ready = !pend_full`.
  - On transfer, `pend <= step_in` and `pend_full <= 1`.
  - `step_valid` while `pend_full` is ignored; the source must hold its value.
- Pending apply (`step <= pend`, `pend_full <= 0`) happens in exactly one of these cases:
  - state IDLE: the cycle after the transfer;
  - state RUN/STOP, cycle with carry = 1: the wrapping add uses the old step; the next add uses the new one;
  - state RUN/STOP with `step == 0`: the next cycle, since no wrap can ever occur.
- State machine:
  - **IDLE:** `acc` holds. `run=1` → RUN, and accumulation starts on the following edge.
  - **RUN:** `acc <= sum` every cycle. `run=0` → STOP.
  - **STOP:**
    - `acc <= sum` until carry. On the carry cycle: `acc <= 0`, `wrap = 1`, → IDLE.
    - `run=1` again → RUN with no discontinuity.
    - `step == 0` → `acc <= 0`, → IDLE next cycle, `wrap = 0`.
- Step `0`: acc frozen in RUN, `wrap` never asserts.
- Maximum step `2^AW-1`: acc decrements by 1 LSB per cycle and `wrap` is asserted every cycle except when `acc` returns to… (carry set whenever `acc ≠ 0` before the add).

## Timing
- Reset values:
  - `acc=0`, `step=0`, `pend=0`, `pend_full=0`
  - `step_ready=1`, `x_s1=0`, `phase_frac=0`, `wrap=0`, `busy=0`, state IDLE.
- `x_s1` and `phase_frac` are direct register outputs, with no combinational path from inputs.
- `run` to first `acc` change is 2 edges: IDLE→RUN on edge 1, first add on edge 2.
- `wrap` is registered and coincides with the wrapped `acc` value.
- `step_ready` falls the cycle after the transfer edge and rises the cycle after the apply edge.
- Transfer and apply in the same cycle are impossible, because the slot is single-entry.
- `rst` mid-operation aborts everything and returns all registers to their reset values on that edge. A pending step is discarded.

## Test plan
- **Reset:** Assert `rst` mid-RUN with `pend_full=1` → next cycle all outputs are at reset values and `step_ready=1`.
- **Basic accumulate** (FRAC_W=8):
  - Stimulus: load step `0x180`, `run=1`.
  - `x_s1` sequence: 1,3,4,6,7,9,10,12,13,15.
  - 11th add: `acc=0x080`, `x_s1=0`, `wrap=1` for exactly one cycle.
- **Glitch-free update:**
  - Stimulus: step `0x100` running, then offer `0x300` at `acc=0x500`.
  - Adds continue at `0x100` through `0xF00` → `0x000` with `wrap`.
  - The following add gives `0x300`; `step_ready` returns high the cycle after.
- **Stop at wrap:**
  - Stimulus: step `0x400`, drop `run` at `acc=0x400`.
  - Sequence: `0x800`, `0xC00`, then `acc=0`, `wrap=1`, `busy=0`.
  - Reasserting `run` at `acc=0x800` instead → accumulation continues and `busy` stays 1.
- **Zero step:**
  - With step 0 in RUN, acc frozen and no `wrap`.
  - Offered step `0x010` is applied the next cycle.
  - `run=0` with step 0 → IDLE next cycle, `acc=0`.
- **Backpressure:** Hold `step_valid` across 3 offers while `pend_full` → only the first value is captured; the later `step_in` changes have no effect until `step_ready` rises.

Source files
------------

// File: rtl/phase_accum_encoder.sv
// Fixed-point phase accumulator feeding the 4-bit phase code to the multiphase clock-select decoder.
// Latency: run to first acc change is 2 edges; x_s1/phase_frac/wrap are registered.
// Backpressure: single-entry step slot; step_ready low while a step waits for a safe apply point.
module phase_accum_encoder #(
    parameter int FRAC_W = 8,
    localparam int AW = 4 + FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [AW-1:0]     step_in,
    input  logic              step_valid,
    output logic              step_ready,
    output logic [3:0]        x_s1,
    output logic [FRAC_W-1:0] phase_frac,
    output logic              wrap,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc, acc_nxt;
    logic [AW-1:0] step;
    logic [AW-1:0] pend;
    logic          pend_full;
    logic          wrap_nxt;
    logic          apply;
    logic          xfer;
    logic [AW:0]   sum_full;
    logic [AW-1:0] sum;
    logic          carry;
    logic          step_zero;

    always_comb begin
        sum_full  = {1'b0, acc} + {1'b0, step};
        sum       = sum_full[AW-1:0];
        carry     = sum_full[AW];
        step_zero = (step == '0);
        xfer      = step_valid & ~pend_full;
    end

    // A pending step only lands where it cannot shift the current phase
    // mid-cycle: while idle, on a wrap, or when a zero step means no wrap will come.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        wrap_nxt  = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                apply = pend_full;
                if (run) state_nxt = RUN;
            end
            RUN: begin
                apply    = pend_full & (carry | step_zero);
                acc_nxt  = sum;
                wrap_nxt = carry;
                if (!run) state_nxt = STOP;
            end
            STOP: begin
                apply = pend_full & (carry | step_zero);
                if (run) begin
                    state_nxt = RUN;
                    acc_nxt   = sum;
                    wrap_nxt  = carry;
                end else if (step_zero) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else if (carry) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    acc_nxt = sum;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            step      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            wrap  <= wrap_nxt;
            if (apply) begin
                step      <= pend;
                pend_full <= 1'b0;
            end else if (xfer) begin
                pend      <= step_in;
                pend_full <= 1'b1;
            end
        end
    end

    assign step_ready = ~pend_full;
    assign x_s1       = acc[AW-1:AW-4];
    assign phase_frac = acc[FRAC_W-1:0];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_phase_accum_encoder.sv
// Directed bench for phase_accum_encoder (FRAC_W=8, 12-bit accumulator).
module tb_phase_accum_encoder;

    localparam int FRAC_W = 8;
    localparam int AW = 4 + FRAC_W;

    logic              clk;
    logic              rst;
    logic              run;
    logic [AW-1:0]     step_in;
    logic              step_valid;
    logic              step_ready;
    logic [3:0]        x_s1;
    logic [FRAC_W-1:0] phase_frac;
    logic              wrap;
    logic              busy;

    int n_cmp;
    int n_err;

    phase_accum_encoder #(.FRAC_W(FRAC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step_in    (step_in),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .x_s1       (x_s1),
        .phase_frac (phase_frac),
        .wrap       (wrap),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] acc_now();
        return {4'h0, x_s1, phase_frac};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        step_valid = 1'b0;
        step_in = '0;
        tick();
        rst = 1'b0;
    endtask

    // Loads a step word while IDLE: transfer edge then apply edge.
    task automatic load_idle(input logic [AW-1:0] v);
        step_in = v;
        step_valid = 1'b1;
        tick();
        chk("load_ready_low", {15'd0, step_ready}, 16'd0);
        step_valid = 1'b0;
        tick();
        chk("load_ready_high", {15'd0, step_ready}, 16'd1);
    endtask

    initial begin
        logic [3:0] basic_seq [10];
        basic_seq = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd13, 4'd15};
        n_cmp = 0;
        n_err = 0;

        // Reset state
        do_reset();
        tick();
        chk("rst_acc", acc_now(), 16'h000);
        chk("rst_ready", {15'd0, step_ready}, 16'd1);
        chk("rst_wrap", {15'd0, wrap}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Basic accumulate with step 0x180
        load_idle(12'h180);
        run = 1'b1;
        tick();
        chk("basic_run_busy", {15'd0, busy}, 16'd1);
        chk("basic_run_acc_hold", acc_now(), 16'h000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("basic_x_s1", {12'd0, x_s1}, {12'd0, basic_seq[i]});
            chk("basic_nowrap", {15'd0, wrap}, 16'd0);
        end
        tick();
        chk("basic_wrap_acc", acc_now(), 16'h080);
        chk("basic_wrap_pulse", {15'd0, wrap}, 16'd1);
        tick();
        chk("basic_wrap_one_cycle", {15'd0, wrap}, 16'd0);
        chk("basic_after_wrap", acc_now(), 16'h200);

        // Reset mid-RUN with a step pending
        step_in = 12'h200;
        step_valid = 1'b1;
        tick();
        chk("rstmid_pend_full", {15'd0, step_ready}, 16'd0);
        rst = 1'b1;
        step_valid = 1'b0;
        run = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstmid_acc", acc_now(), 16'h000);
        chk("rstmid_ready", {15'd0, step_ready}, 16'd1);
        chk("rstmid_busy", {15'd0, busy}, 16'd0);
        chk("rstmid_wrap", {15'd0, wrap}, 16'd0);
        run = 1'b1;
        tick();
        tick();
        chk("rstmid_pend_discarded", acc_now(), 16'h000);
        do_reset();

        // Glitch-free step update
        load_idle(12'h100);
        run = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) tick();
        chk("glitch_acc_500", acc_now(), 16'h500);
        step_in = 12'h300;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        chk("glitch_xfer_ready", {15'd0, step_ready}, 16'd0);
        chk("glitch_acc_600", acc_now(), 16'h600);
        for (int i = 7; i <= 15; i++) begin
            tick();
            chk("glitch_old_step", acc_now(), 16'(i * 16'h100));
            chk("glitch_ready_low", {15'd0, step_ready}, 16'd0);
        end
        tick();
        chk("glitch_wrap_acc", acc_now(), 16'h000);
        chk("glitch_wrap", {15'd0, wrap}, 16'd1);
        chk("glitch_ready_back", {15'd0, step_ready}, 16'd1);
        tick();
        chk("glitch_new_step", acc_now(), 16'h300);
        chk("glitch_wrap_clear", {15'd0, wrap}, 16'd0);
        do_reset();

        // Stop at wrap
        load_idle(12'h400);
        run = 1'b1;
        tick();
        tick();
        chk("stop_acc_400", acc_now(), 16'h400);
        run = 1'b0;
        tick();
        chk("stop_acc_800", acc_now(), 16'h800);
        chk("stop_busy_800", {15'd0, busy}, 16'd1);
        tick();
        chk("stop_acc_c00", acc_now(), 16'hC00);
        chk("stop_nowrap_c00", {15'd0, wrap}, 16'd0);
        tick();
        chk("stop_acc_zero", acc_now(), 16'h000);
        chk("stop_wrap", {15'd0, wrap}, 16'd1);
        chk("stop_idle", {15'd0, busy}, 16'd0);
        tick();
        chk("stop_idle_hold", acc_now(), 16'h000);
        chk("stop_wrap_clear", {15'd0, wrap}, 16'd0);

        // Reassert run while stopping
        run = 1'b1;
        tick();
        tick();
        chk("resume_acc_400", acc_now(), 16'h400);
        run = 1'b0;
        tick();
        chk("resume_acc_800", acc_now(), 16'h800);
        run = 1'b1;
        tick();
        chk("resume_acc_c00", acc_now(), 16'hC00);
        chk("resume_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("resume_wrap_acc", acc_now(), 16'h000);
        chk("resume_wrap", {15'd0, wrap}, 16'd1);
        chk("resume_busy_wrap", {15'd0, busy}, 16'd1);
        tick();
        chk("resume_continue", acc_now(), 16'h400);
        do_reset();

        // Zero step: apply 0 at a wrap leaving a nonzero phase
        load_idle(12'hF01);
        run = 1'b1;
        tick();
        step_in = 12'h000;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        chk("zero_acc_f01", acc_now(), 16'hF01);
        tick();
        chk("zero_acc_e02", acc_now(), 16'hE02);
        chk("zero_wrap_e02", {15'd0, wrap}, 16'd1);
        chk("zero_applied_ready", {15'd0, step_ready}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_frozen", acc_now(), 16'hE02);
            chk("zero_nowrap", {15'd0, wrap}, 16'd0);
        end
        run = 1'b0;
        tick();
        chk("zero_stop_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("zero_idle", {15'd0, busy}, 16'd0);
        chk("zero_idle_acc", acc_now(), 16'h000);
        chk("zero_idle_wrap", {15'd0, wrap}, 16'd0);
        run = 1'b1;
        tick();
        step_in = 12'h010;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        chk("zero_xfer_ready", {15'd0, step_ready}, 16'd0);
        tick();
        chk("zero_apply_ready", {15'd0, step_ready}, 16'd1);
        chk("zero_apply_acc", acc_now(), 16'h000);
        tick();
        chk("zero_new_010", acc_now(), 16'h010);
        tick();
        chk("zero_new_020", acc_now(), 16'h020);
        do_reset();

        // Maximum step decrements by one LSB
        load_idle(12'hFFF);
        run = 1'b1;
        tick();
        tick();
        chk("max_acc_fff", acc_now(), 16'hFFF);
        chk("max_nowrap_from0", {15'd0, wrap}, 16'd0);
        tick();
        chk("max_acc_ffe", acc_now(), 16'hFFE);
        chk("max_wrap_ffe", {15'd0, wrap}, 16'd1);
        tick();
        chk("max_acc_ffd", acc_now(), 16'hFFD);
        chk("max_wrap_ffd", {15'd0, wrap}, 16'd1);
        do_reset();

        // Backpressure: held valid with changing data while slot is full
        load_idle(12'h100);
        run = 1'b1;
        tick();
        step_in = 12'h200;
        step_valid = 1'b1;
        tick();
        chk("bp_acc_100", acc_now(), 16'h100);
        chk("bp_ready_0", {15'd0, step_ready}, 16'd0);
        step_in = 12'h300;
        tick();
        chk("bp_ready_1", {15'd0, step_ready}, 16'd0);
        step_in = 12'h500;
        tick();
        chk("bp_ready_2", {15'd0, step_ready}, 16'd0);
        step_in = 12'h700;
        tick();
        chk("bp_acc_400", acc_now(), 16'h400);
        for (int i = 5; i <= 15; i++) tick();
        chk("bp_acc_f00", acc_now(), 16'hF00);
        chk("bp_ready_held", {15'd0, step_ready}, 16'd0);
        tick();
        chk("bp_wrap", {15'd0, wrap}, 16'd1);
        chk("bp_ready_rise", {15'd0, step_ready}, 16'd1);
        step_valid = 1'b0;
        tick();
        chk("bp_first_captured", acc_now(), 16'h200);
        tick();
        chk("bp_first_captured_2", acc_now(), 16'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
